// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch prediction, Execute-stage training
// and mispredict recovery. Define GSHARE_EN to XOR a global history register into the counter index.
module branch_predictor #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ENTRIES    = 64,
    localparam int IDX_W      = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef GSHARE_EN
    output logic [IDX_W-1:0]      GhrF_o,
    input  logic [IDX_W-1:0]      GhrE_i,
`endif
    input  logic [DATA_WIDTH-1:0] PCF_i,
    output logic                  PredTakenF_o,
    output logic [DATA_WIDTH-1:0] PredTargetF_o,
    input  logic                  UpdateE_i,
    input  logic [DATA_WIDTH-1:0] PCE_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
    input  logic                  TakenE_i,
    input  logic [DATA_WIDTH-1:0] TargetE_i,
    input  logic                  PredTakenE_i,
    input  logic [DATA_WIDTH-1:0] PredTargetE_i,
    output logic                  MispredictE_o,
    output logic [DATA_WIDTH-1:0] RecoverPCE_o
);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;

    logic                  valid_q  [ENTRIES];
    logic                  valid_d  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_d    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    logic [DATA_WIDTH-1:0] target_d [ENTRIES];
    ctr_e                  ctr_q    [ENTRIES];
    ctr_e                  ctr_d    [ENTRIES];

    logic [IDX_W-1:0] idx_f_s, idx_e_s, cidx_f_s, cidx_e_s;
    logic [TAG_W-1:0] tag_f_s, tag_e_s;
    logic             hit_f_s, hit_e_s, mispredict_s;
    logic             unused_s;

    function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
        ctr_e nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

    assign idx_f_s  = PCF_i[IDX_W+1:2];
    assign tag_f_s  = PCF_i[DATA_WIDTH-1:IDX_W+2];
    assign idx_e_s  = PCE_i[IDX_W+1:2];
    assign tag_e_s  = PCE_i[DATA_WIDTH-1:IDX_W+2];
    assign unused_s = ^{PCF_i[1:0], PCE_i[1:0]};

`ifdef GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    assign cidx_f_s = idx_f_s ^ ghr_q;
    assign cidx_e_s = idx_e_s ^ GhrE_i;
    assign GhrF_o   = ghr_q;

    // Non-speculative history: shifts only on resolved branches/jumps.
    always_comb begin
        ghr_d = ghr_q;
        if (UpdateE_i) begin
            ghr_d = {ghr_q[IDX_W-2:0], TakenE_i};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // History register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= {IDX_W{1'b0}};
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign cidx_f_s = idx_f_s;
    assign cidx_e_s = idx_e_s;
`endif

    assign hit_f_s       = valid_q[idx_f_s] && (tag_q[idx_f_s] == tag_f_s);
    assign hit_e_s       = valid_q[idx_e_s] && (tag_q[idx_e_s] == tag_e_s);
    assign PredTakenF_o  = hit_f_s & ctr_q[cidx_f_s][1];
    assign PredTargetF_o = target_q[idx_f_s];

    // Table training from Execute: step on hit, allocate on taken miss, drop stale entries.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
        end
        if (UpdateE_i) begin
            if (hit_e_s) begin
                ctr_d[cidx_e_s] = ctr_step(ctr_q[cidx_e_s], TakenE_i);
                if (TakenE_i) begin
                    target_d[idx_e_s] = TargetE_i;
                end else begin
                    target_d[idx_e_s] = target_q[idx_e_s];
                end
            end else if (TakenE_i) begin
                valid_d[idx_e_s]  = 1'b1;
                tag_d[idx_e_s]    = tag_e_s;
                target_d[idx_e_s] = TargetE_i;
                ctr_d[cidx_e_s]   = WT;
            end else begin
                valid_d[idx_e_s] = valid_q[idx_e_s];
            end
        end else if (PredTakenE_i) begin
            // A non-branch was predicted taken: the entry that produced it is stale.
            valid_d[idx_e_s] = 1'b0;
        end else begin
            valid_d[idx_e_s] = valid_q[idx_e_s];
        end
    end

    // Table storage; reset wipes all training in one cycle and discards any concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= {DATA_WIDTH{1'b0}};
                ctr_q[i]    <= WNT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

    // Redirect decision for the instruction in Execute.
    always_comb begin
        mispredict_s = 1'b0;
        if (UpdateE_i) begin
            mispredict_s = (TakenE_i != PredTakenE_i) ||
                           (TakenE_i && (TargetE_i != PredTargetE_i));
        end else begin
            mispredict_s = PredTakenE_i;
        end
    end

    assign MispredictE_o = mispredict_s;
    assign RecoverPCE_o  = (UpdateE_i && TakenE_i) ? TargetE_i : PCPlus4E_i;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then randomized traffic against a behavioural model.
module tb_branch_predictor;
    localparam int ENTRIES = 64;
    localparam int TAG_SH  = $clog2(ENTRIES) + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcf, pce, pcp4e, tgte, ptgte, ptgtf, recpc;
    logic        upd, tke, ptke, ptkf, mis;

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .PCF_i(pcf), .PredTakenF_o(ptkf), .PredTargetF_o(ptgtf),
        .UpdateE_i(upd), .PCE_i(pce), .PCPlus4E_i(pcp4e), .TakenE_i(tke), .TargetE_i(tgte),
        .PredTakenE_i(ptke), .PredTargetE_i(ptgte), .MispredictE_o(mis), .RecoverPCE_o(recpc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] rec;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: whole PCs per slot, counter kept as an integer 0..3.
    bit          m_valid [ENTRIES];
    logic [31:0] m_pc    [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];

    function automatic int slot(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[slot(pc)] && ((m_pc[slot(pc)] >> TAG_SH) == (pc >> TAG_SH));
    endfunction

    function automatic bit m_predict(logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_pc[i] = 32'h0; m_tgt[i] = 32'h0; m_ctr[i] = 1;
        end
    endtask

    task automatic step(input bit r, input logic [31:0] f_pc, input bit u, input logic [31:0] e_pc,
                        input bit tk, input logic [31:0] tg, input bit ptk, input logic [31:0] ptg);
        exp_t e;
        int   s;
        @(posedge clk); #1;
        rst = r; pcf = f_pc; upd = u; pce = e_pc; pcp4e = e_pc + 32'd4;
        tke = tk; tgte = tg; ptke = ptk; ptgte = ptg;
        e.pt   = m_predict(f_pc);
        e.ptgt = m_tgt[slot(f_pc)];
        e.mis  = u ? ((tk != ptk) || (tk && (tg != ptg))) : ptk;
        e.rec  = (u && tk) ? tg : e_pc + 32'd4;
        exp_q.push_back(e);
        s = slot(e_pc);
        if (r) begin
            m_reset();
        end else if (u) begin
            if (m_hit(e_pc)) begin
                m_ctr[s] = tk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
                if (tk) m_tgt[s] = tg;
            end else if (tk) begin
                m_valid[s] = 1'b1; m_pc[s] = e_pc; m_tgt[s] = tg; m_ctr[s] = 2;
            end
        end else if (ptk) begin
            m_valid[s] = 1'b0;
        end
    endtask

    task automatic look(input logic [31:0] f_pc);
        step(1'b0, f_pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the combinational outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pred_taken",  {31'b0, ptkf}, {31'b0, e.pt});
            chk("pred_target", ptgtf, e.ptgt);
            chk("mispredict",  {31'b0, mis},  {31'b0, e.mis});
            chk("recover_pc",  recpc, e.rec);
        end
    end

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 2)) << TAG_SH) |
               32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] rp, ep, tg, ptg;
        bit          u, tk, ptk, r;
        rst = 1'b1; pcf = 32'h0; upd = 1'b0; pce = 32'h0; pcp4e = 32'h4;
        tke = 1'b0; tgte = 32'h0; ptke = 1'b0; ptgte = 32'h0;
        m_reset();
        repeat (2) @(posedge clk);

        // Reset state and first allocation.
        look(32'h40);
        step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        look(32'h40);
        // Not-taken training down to SNT.
        step(1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        look(32'h40);
        step(1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        look(32'h40);
        // Aliasing entry replaces the previous occupant.
        step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        step(1'b0, 32'h40, 1'b1, 32'h40 + 32'(4 * ENTRIES), 1'b1, 32'h200, 1'b0, 32'h0);
        look(32'h40);
        look(32'h40 + 32'(4 * ENTRIES));
        // JALR target change; same-cycle read sees old target.
        step(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
        step(1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h304, 1'b1, 32'h300);
        look(32'h80);
        // Stale hit on a non-branch invalidates the entry.
        step(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        step(1'b0, 32'h40, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        look(32'h40);
        // Reset discards a concurrent update and all training.
        step(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0, 32'h0);
        look(32'h80);
        look(32'h40 + 32'(4 * ENTRIES));

        for (int n = 0; n < 3000; n++) begin
            rp = rand_pc();
            ep = rand_pc();
            u  = ($urandom_range(0, 3) != 0);
            tk = 1'($urandom_range(0, 1));
            tg = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 1) == 0) begin
                ptk = m_predict(ep);
                ptg = m_tgt[slot(ep)];
            end else begin
                ptk = 1'($urandom_range(0, 1));
                ptg = 32'($urandom_range(0, 255)) << 2;
            end
            r = ($urandom_range(0, 199) == 0);
            step(r, rp, u, ep, tk, tg, ptk, ptg);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
